// File: rtl/display_scanner_if.sv
// Display scanner bus: the live value and display controls flow toward the scanner,
// and the digit nibble, anode enables and frame strobe flow back out.
interface display_scanner_if #(
  parameter int unsigned NUM_DIGITS = 8
) ();

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   enable_mask;
  logic                    lz_blank;
  logic [3:0]              display_out;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    frame_start;

  // Controller side: supplies value and controls, observes the scan outputs.
  modport master (
    output value, enable_mask, lz_blank,
    input  display_out, AN, frame_start
  );

  // Scanner side.
  modport slave (
    input  value, enable_mask, lz_blank,
    output display_out, AN, frame_start
  );

endinterface

// File: rtl/display_scanner.sv
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared 7-segment decoder.
// The input value is snapshotted once per frame so a frame never tears. Digits can
// be individually disabled or blanked as leading zeros. Each digit slot starts with
// DEADTIME dark cycles to suppress ghosting.
module display_scanner #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PRESCALE   = 100000,
  parameter int unsigned DEADTIME   = 4
) (
  input  logic             clk,
  input  logic             reset,
  display_scanner_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PMax  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PDead = PW'(DEADTIME);
  localparam logic [IW-1:0] ILast = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           p_q, p_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    fs_q, fs_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              dout_q, dout_d;

  logic                    tick;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;

  assign tick = (p_q == PMax);
  assign p_d  = tick ? '0 : p_q + 1'b1;

  // Unpack the snapshot into per-digit nibbles.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = snap_q[4*i +: 4];
    end
  end

  // Leading-zero blanking: digit i (i >= 1) is blanked when it and every higher
  // snapshot nibble are zero. Digit 0 always shows so a zero value reads "0".
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (nib[i] == 4'h0);
      if (i != 0) begin
        blank[i] = bus.lz_blank & all_zero;
      end
    end
  end

  // Scan FSM next state: snapshot the value and pulse frame_start at each frame boundary.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    fs_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          snap_d  = bus.value;
          idx_d   = '0;
          fs_d    = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (tick) begin
          if (idx_q == ILast) begin
            idx_d  = '0;
            snap_d = bus.value;
            fs_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the current state; the result is registered, giving one cycle of lag.
  always_comb begin
    an_d   = '1;
    dout_d = 4'h0;
    if (state_q == StScan) begin
      dout_d = nib[idx_q];
      if ((p_q >= PDead) && bus.enable_mask[idx_q] && !blank[idx_q]) begin
        an_d[idx_q] = 1'b0;
      end
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      p_q     <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      fs_q    <= 1'b0;
      an_q    <= '1;
      dout_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      fs_q    <= fs_d;
      an_q    <= an_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.display_out = dout_q;
  assign bus.AN          = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with NUM_DIGITS=4, PRESCALE=4, DEADTIME=1.
// Each table record holds the inputs driven during one cycle and the outputs
// expected in that same cycle. Outputs are sampled on the falling edge.
module tb_display_scanner;

  localparam int unsigned ND = 4;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  mask;
    logic        lz;
    logic [3:0]  an;
    logic [3:0]  dout;
    logic        fs;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  display_scanner #(
    .NUM_DIGITS(ND),
    .PRESCALE  (4),
    .DEADTIME  (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void addv(logic [15:0] v, logic [3:0] m, logic lz,
                               logic [3:0] an, logic [3:0] d, logic fs);
    vec_t r;
    r.value = v; r.mask = m; r.lz = lz; r.an = an; r.dout = d; r.fs = fs;
    vecs.push_back(r);
  endfunction

  // One 4-cycle output slot: a dark cycle, then three cycles at an_lit.
  function automatic void add_slot(logic [15:0] v, logic [3:0] m, logic lz,
                                   logic [3:0] an_lit, logic [3:0] d, logic fs_last);
    addv(v, m, lz, 4'hF, d, 1'b0);
    addv(v, m, lz, an_lit, d, 1'b0);
    addv(v, m, lz, an_lit, d, 1'b0);
    addv(v, m, lz, an_lit, d, fs_last);
  endfunction

  task automatic drive(input logic [15:0] v, input logic [3:0] m, input logic lz);
    bus.value       = v;
    bus.enable_mask = m;
    bus.lz_blank    = lz;
  endtask

  task automatic check_out(input string name, input logic [3:0] an,
                           input logic [3:0] d, input logic fs);
    n_vec++;
    if (bus.AN !== an || bus.display_out !== d || bus.frame_start !== fs) begin
      n_err++;
      $display("FAIL %s: got AN=%b dout=%h fs=%b, want AN=%b dout=%h fs=%b",
               name, bus.AN, bus.display_out, bus.frame_start, an, d, fs);
    end
  endtask

  // Caller is positioned at the falling edge of the first vector's cycle.
  task automatic run_vectors(input int first, input int last, input string tag);
    for (int k = first; k <= last; k++) begin
      if (k != first) @(negedge clk);
      drive(vecs[k].value, vecs[k].mask, vecs[k].lz);
      check_out($sformatf("%s[%0d]", tag, k), vecs[k].an, vecs[k].dout, vecs[k].fs);
    end
  endtask

  task automatic reset_and_release();
    reset = 1'b1;
    drive(16'h1234, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Idle period after reset, then the first frame_start
    for (int k = 0; k < 4; k++) addv(16'h1234, 4'hF, 1'b0, 4'hF, 4'h0, 1'b0);
    addv(16'h1234, 4'hF, 1'b0, 4'hF, 4'h0, 1'b1);
    // Frame 1: snapshot 1234. Value switches to ABCD mid-frame but the display stays on 1234
    add_slot(16'h1234, 4'hF, 1'b0, 4'b1110, 4'h4, 1'b0);
    add_slot(16'h1234, 4'hF, 1'b0, 4'b1101, 4'h3, 1'b0);
    add_slot(16'hABCD, 4'hF, 1'b0, 4'b1011, 4'h2, 1'b0);
    add_slot(16'hABCD, 4'hF, 1'b0, 4'b0111, 4'h1, 1'b1);
    // Frame 2: snapshot ABCD
    add_slot(16'hABCD, 4'hF, 1'b0, 4'b1110, 4'hD, 1'b0);
    add_slot(16'hABCD, 4'hF, 1'b0, 4'b1101, 4'hC, 1'b0);
    add_slot(16'hABCD, 4'hF, 1'b0, 4'b1011, 4'hB, 1'b0);
    add_slot(16'hABCD, 4'hF, 1'b0, 4'b0111, 4'hA, 1'b1);
    // Frame 3: enable_mask=1011 keeps digit 2 dark, and 0050 is staged for the next snapshot
    add_slot(16'hABCD, 4'b1011, 1'b0, 4'b1110, 4'hD, 1'b0);
    add_slot(16'hABCD, 4'b1011, 1'b0, 4'b1101, 4'hC, 1'b0);
    add_slot(16'hABCD, 4'b1011, 1'b0, 4'hF,    4'hB, 1'b0);
    add_slot(16'h0050, 4'b1011, 1'b0, 4'b0111, 4'hA, 1'b1);
    // Frame 4: snapshot 0050 with lz_blank; digits 3 and 2 are blanked
    add_slot(16'h0050, 4'hF, 1'b1, 4'b1110, 4'h0, 1'b0);
    add_slot(16'h0050, 4'hF, 1'b1, 4'b1101, 4'h5, 1'b0);
    add_slot(16'h0050, 4'hF, 1'b1, 4'hF,    4'h0, 1'b0);
    add_slot(16'h0000, 4'hF, 1'b1, 4'hF,    4'h0, 1'b1);
    // Frame 5: snapshot 0000 with lz_blank; only digit 0 lights
    add_slot(16'h0000, 4'hF, 1'b1, 4'b1110, 4'h0, 1'b0);
    add_slot(16'h0000, 4'hF, 1'b1, 4'hF,    4'h0, 1'b0);
    add_slot(16'h0000, 4'hF, 1'b1, 4'hF,    4'h0, 1'b0);
    add_slot(16'h1004, 4'hF, 1'b1, 4'hF,    4'h0, 1'b1);
    // Frame 6: snapshot 1004; inner zeros below a nonzero MSD are not blanked
    add_slot(16'h1004, 4'hF, 1'b1, 4'b1110, 4'h4, 1'b0);
    add_slot(16'h1004, 4'hF, 1'b1, 4'b1101, 4'h0, 1'b0);
    add_slot(16'h1004, 4'hF, 1'b1, 4'b1011, 4'h0, 1'b0);
    add_slot(16'h1004, 4'hF, 1'b1, 4'b0111, 4'h1, 1'b1);

    reset_and_release();
    run_vectors(0, vecs.size() - 1, "vec");

    // Reset during digit 2's lit phase
    begin
      bit found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge clk);
        if (bus.AN === 4'b1011) found = 1'b1;
      end
      n_vec++;
      if (!found) begin
        n_err++;
        $display("FAIL wait_digit2_lit: got AN=%b, want AN=1011 within 40 cycles", bus.AN);
      end
      reset = 1'b1;
      @(negedge clk);
      check_out("midscan_reset", 4'hF, 4'h0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_vectors(0, 20, "restart");
    end

    // Random inputs: check the anode invariants and frame timing. The last vector
    // checked above had frame_start high, so the frame count restarts here.
    begin
      int cyc = 0;
      int last_fs = 0;
      for (int n = 0; n < 1600; n++) begin
        int d;
        int dd;
        int slot;
        logic [3:0] lit;
        @(negedge clk);
        cyc++;
        d = cyc - last_fs;
        n_vec++;
        if (bus.frame_start !== (d == 16)) begin
          n_err++;
          $display("FAIL rnd_frame_start cyc %0d: got fs=%b, want fs=%b", cyc,
                   bus.frame_start, (d == 16));
        end
        if (bus.frame_start === 1'b1) begin
          last_fs = cyc;
          d = 0;
        end
        n_vec++;
        if ($countones(~bus.AN) > 1) begin
          n_err++;
          $display("FAIL rnd_onehot cyc %0d: got AN=%b, want at most one bit low", cyc, bus.AN);
        end
        dd   = (d == 0) ? 16 : d;
        slot = ((dd - 1) / 4) % 4;
        lit  = ~(4'b0001 << slot);
        n_vec++;
        if (((dd - 1) % 4) == 0) begin
          if (bus.AN !== 4'hF) begin
            n_err++;
            $display("FAIL rnd_dead cyc %0d: got AN=%b, want AN=1111", cyc, bus.AN);
          end
        end else if (bus.AN !== 4'hF && bus.AN !== lit) begin
          n_err++;
          $display("FAIL rnd_slot cyc %0d: got AN=%b, want 1111 or %b", cyc, bus.AN, lit);
        end
        drive(16'($urandom), 4'($urandom), 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
Time-multiplexes NUM_DIGITS hex nibbles onto one shared 7-segment decoder. It is the stage directly upstream of the hex-to-segment decoder. Each cycle it presents one 4-bit nibble on display_out (fed to the decoder) and drives the active-low digit anodes AN. It snapshots the input value once per frame to prevent tearing, supports per-digit enable and leading-zero blanking, and inserts an anode dead-time between digits to suppress ghosting.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (≥2).
PRESCALE, 100000, clock cycles per digit slot (≥2). 100 MHz gives 1 kHz per digit.
DEADTIME, 4, cycles at slot start with all anodes off (0 ≤ DEADTIME < PRESCALE).

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  synchronous, active-high reset.
value  input  4*NUM_DIGITS  hex value to display; nibble i = value[4i+3:4i]; digit 0 is the LSD.
enable_mask  input  NUM_DIGITS  1 = digit i may light.
lz_blank  input  1  1 = blank leading-zero digits.
display_out  output  4  nibble for the current digit, to the segment decoder.
AN  output  NUM_DIGITS  active-low anode enables; at most one bit low.
frame_start  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; ports are named clk and reset.
- Reset state: state=IDLE, prescaler p=0, idx=0, snapshot=0, AN=all ones, display_out=4'h0, frame_start=0.
- Prescaler: p counts 0..PRESCALE-1 and wraps. A tick occurs in the cycle where p==PRESCALE-1.
- FSM, IDLE:
  - AN stays all ones.
  - On a tick: snapshot<=value, idx<=0, frame_start<=1, next state SCAN.
- FSM, SCAN:
  - On a tick with idx<NUM_DIGITS-1: idx<=idx+1.
  - On a tick with idx==NUM_DIGITS-1: idx<=0, snapshot<=value, frame_start<=1.
  - frame_start is 0 in every other cycle.
- Outputs are registered and lag internal state by exactly one cycle: AN and display_out at cycle t+1 are computed from state, p, idx and snapshot at cycle t.
- display_out = snapshot nibble[idx] in SCAN; 4'h0 in IDLE. It is driven even while the digit is dark.
- Digit idx is lit (AN[idx]=0, all other AN bits 1) iff all of the following hold:
  - state==SCAN;
  - p ≥ DEADTIME;
  - enable_mask[idx]==1;
  - the digit is not leading-zero-blanked.
  - Otherwise AN = all ones.
- Leading-zero blanking: with lz_blank=1, digit i (i≥1) is blanked iff snapshot nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked, so a zero value shows a single "0". With lz_blank=0, nothing is blanked.
- The blanking decision uses the snapshot, not the live value.
- value, enable_mask and lz_blank may change at any time:
  - value affects the display only at the next snapshot;
  - enable_mask and lz_blank take effect on the next cycle.
- Frame period = NUM_DIGITS*PRESCALE cycles. The first frame_start occurs PRESCALE cycles after reset deasserts.
- Reset mid-scan: the cycle after reset is sampled, AN=all ones, and the FSM returns to IDLE with p=0.
- Counter widths: p is clog2(PRESCALE) bits and idx is clog2(NUM_DIGITS) bits. Neither may take a value outside its range.

Test Plan:
(Bench parameters: NUM_DIGITS=4, PRESCALE=4, DEADTIME=1.)
1. Power-up: hold reset 3 cycles, then release, with value=16'h1234 and enable_mask=4'hF -> AN=4'hF for the first 4 cycles. frame_start pulses once at cycle 4. The following 4-cycle slots show display_out=4,3,2,1, each with 1 dark cycle then AN=1110, 1101, 1011, 0111 for 3 cycles.
2. lz_blank=1, value=16'h0050 -> digits 3 and 2 stay dark (AN[3]=AN[2]=1 always). Digit 1 shows 5 and digit 0 shows 0. With value=16'h0000, only AN[0] ever goes low.
3. Snapshot: change value from 16'h1234 to 16'hABCD mid-frame -> remaining slots still show 1234 nibbles. After the next frame_start they show D,C,B,A.
4. enable_mask=4'b1011 -> AN[2] never low; the other digits are unaffected and timing is unchanged.
5. Reset asserted during digit 2's lit phase -> AN=4'hF next cycle. The restart sequence matches scenario 1.
6. Assertions over a long random run: at most one AN bit low; frame_start spacing is exactly 16 cycles; AN all ones in the first cycle of every slot.
